// File: rtl/butterfly_pkg.sv
// butterfly_pkg
// Shared definitions for the butterfly sequencing controller:
//   state_t  - 5-bit FSM state; the code doubles as the phase shown on the display
//   ctrl_t   - packed control vector driven to butterfly_datapath
//   CTRL_*   - bit index of each control line within ctrl_t
//   ctrl_for - control vector that must be active while the FSM sits in a state
//   is_wait  - true for states that wait for an operator key press
package butterfly_pkg;

  typedef enum logic [4:0] {
    W_REW = 5'd0,  L_REW = 5'd1,  W_IMW = 5'd2,  L_IMW = 5'd3,
    W_REB = 5'd4,  L_REB = 5'd5,  W_IMB = 5'd6,  L_IMB = 5'd7,
    M1    = 5'd8,  M2    = 5'd9,  M3    = 5'd10, M4    = 5'd11,
    W_REA = 5'd12, L_REA = 5'd13, Y_RE  = 5'd14, W_YR  = 5'd15,
    R_RE  = 5'd16, Z_RE  = 5'd17, W_ZR  = 5'd18, M5    = 5'd19,
    W_IMA = 5'd20, L_IMA = 5'd21, Y_IM  = 5'd22, W_YI  = 5'd23,
    R_IM  = 5'd24, Z_IM  = 5'd25, W_ZI  = 5'd26
  } state_t;

  typedef struct packed {
    logic load_coeff;
    logic load_b;
    logic load_mult;
    logic multiply;
    logic load_output_reg;
    logic subtract;
    logic mult_out_select;
    logic fbr_input;
  } ctrl_t;

  localparam int CTRL_LOAD_COEFF      = 7;
  localparam int CTRL_LOAD_B          = 6;
  localparam int CTRL_LOAD_MULT       = 5;
  localparam int CTRL_MULTIPLY        = 4;
  localparam int CTRL_LOAD_OUTPUT_REG = 3;
  localparam int CTRL_SUBTRACT        = 2;
  localparam int CTRL_MULT_OUT_SELECT = 1;
  localparam int CTRL_FBR_INPUT       = 0;

  // Wait states and illegal codes map to an all-zero vector.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      L_REW, L_IMW: c.load_coeff = 1'b1;
      L_REB, L_IMB: c.load_b = 1'b1;
      M1: begin
        c.load_mult = 1'b1;
        c.load_b    = 1'b1;
        c.subtract  = 1'b1;
      end
      M2: begin
        c.multiply = 1'b1;
        c.subtract = 1'b1;
      end
      M3: begin
        c.load_mult = 1'b1;
        c.load_b    = 1'b1;
      end
      M4, M5: c.multiply = 1'b1;
      L_REA, L_IMA: begin
        c.fbr_input       = 1'b1;
        c.load_output_reg = 1'b1;
      end
      Y_RE, Y_IM: c.load_output_reg = 1'b1;
      R_RE, R_IM: begin
        c.load_output_reg = 1'b1;
        c.mult_out_select = 1'b1;
      end
      Z_RE, Z_IM: begin
        c.load_output_reg = 1'b1;
        c.subtract        = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_wait(input state_t s);
    logic w;
    case (s)
      W_REW, W_IMW, W_REB, W_IMB, W_REA,
      W_YR, W_ZR, W_IMA, W_YI, W_ZI: w = 1'b1;
      default:                       w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/butterfly_controller_step_debouncer.sv
// step_debouncer
// Turns the raw, asynchronous step key into a single-cycle accept pulse per press.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high; leaves the debouncer disarmed
//   step   in  raw key level, active-high
//   accept out one-cycle pulse when a press has been stable for DEBOUNCE_CYCLES cycles
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          armed;
  logic [CW-1:0] count;

  // One counter serves both directions: while armed it counts consecutive high
  // cycles (a press), while disarmed it counts consecutive low cycles (a release).
  // Completing a run flips the armed flag, and only the press run emits accept.
  // Starting disarmed means a key held through reset must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      armed  <= 1'b0;
      count  <= '0;
      accept <= 1'b0;
    end else begin
      sync_1 <= step;
      sync_2 <= sync_1;
      accept <= 1'b0;
      if (sync_2 != armed) begin
        count <= '0;
      end else if (count == LAST) begin
        count  <= '0;
        armed  <= ~armed;
        accept <= armed;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/butterfly_controller.sv
// butterfly_controller
// Sequencing FSM for butterfly_datapath. The operator enters w, b and a one byte
// at a time and presses step after each; results appear on LEDR in W_YR/W_ZR/W_YI/W_ZI.
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   step                raw key, active-high
//   load_coeff .. fbr_input  registered datapath control lines
//   phase               current state code (0..26)
//   waiting             1 while the FSM waits for the operator
module butterfly_controller
  import butterfly_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic       load_coeff,
  output logic       load_b,
  output logic       load_mult,
  output logic       multiply,
  output logic       load_output_reg,
  output logic       subtract,
  output logic       mult_out_select,
  output logic       fbr_input,
  output logic [4:0] phase,
  output logic       waiting
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  ctrl_t  next_ctrl;
  logic   accept;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .accept(accept)
  );

  // Controls are registered alongside the state from the same next-state decode,
  // so each vector is valid for exactly the cycles the FSM occupies its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= W_REW;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= next_ctrl;
    end
  end

  // The state codes follow the operating order, so advancing is an increment.
  // An accept outside a wait state is simply dropped.
  always_comb begin
    next_state = W_REW;
    next_ctrl  = '0;
    if (state > W_ZI) begin
      next_state = W_REW;
    end else if (state == W_ZI) begin
      next_state = accept ? W_REW : W_ZI;
    end else if (is_wait(state)) begin
      next_state = accept ? state_t'(state + 5'd1) : state;
    end else begin
      next_state = state_t'(state + 5'd1);
    end
    next_ctrl = ctrl_for(next_state);
  end

  assign load_coeff      = ctrl_q[CTRL_LOAD_COEFF];
  assign load_b          = ctrl_q[CTRL_LOAD_B];
  assign load_mult       = ctrl_q[CTRL_LOAD_MULT];
  assign multiply        = ctrl_q[CTRL_MULTIPLY];
  assign load_output_reg = ctrl_q[CTRL_LOAD_OUTPUT_REG];
  assign subtract        = ctrl_q[CTRL_SUBTRACT];
  assign mult_out_select = ctrl_q[CTRL_MULT_OUT_SELECT];
  assign fbr_input       = ctrl_q[CTRL_FBR_INPUT];
  assign phase           = state;
  assign waiting         = is_wait(state);

endmodule

// File: tb/tb_butterfly_controller.sv
// tb_butterfly_controller
// Self-checking bench for butterfly_controller with a short debounce window.
// A table-driven model of the operating sequence follows the FSM one cycle at a
// time; key presses of random length and gap are applied and every cycle's phase,
// control vector and waiting flag are compared against the model.
module tb_butterfly_controller;

  localparam int DEB = 4;

  localparam logic [7:0] LC = 8'h80;
  localparam logic [7:0] LB = 8'h40;
  localparam logic [7:0] LM = 8'h20;
  localparam logic [7:0] MU = 8'h10;
  localparam logic [7:0] LO = 8'h08;
  localparam logic [7:0] SU = 8'h04;
  localparam logic [7:0] MS = 8'h02;
  localparam logic [7:0] FB = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic       load_coeff;
  logic       load_b;
  logic       load_mult;
  logic       multiply;
  logic       load_output_reg;
  logic       subtract;
  logic       mult_out_select;
  logic       fbr_input;
  logic [4:0] phase;
  logic       waiting;
  logic [7:0] ctrl_obs;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_ctrl [27];
  bit         exp_wait [27];
  int         exp_phase;
  bit         allow_accept;
  int         advances;
  int         since_rise;
  int         adv_latency;

  always #5 clk = ~clk;

  butterfly_controller #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .step           (step),
    .load_coeff     (load_coeff),
    .load_b         (load_b),
    .load_mult      (load_mult),
    .multiply       (multiply),
    .load_output_reg(load_output_reg),
    .subtract       (subtract),
    .mult_out_select(mult_out_select),
    .fbr_input      (fbr_input),
    .phase          (phase),
    .waiting        (waiting)
  );

  assign ctrl_obs = {load_coeff, load_b, load_mult, multiply,
                     load_output_reg, subtract, mult_out_select, fbr_input};

  function automatic int next_phase(input int p);
    return (p == 26) ? 0 : p + 1;
  endfunction

  // Advance one clock, step the model, and compare all outputs.
  // In a wait state the model follows an advance only while a press is allowed.
  task automatic check_output();
    @(posedge clk);
    #1;
    since_rise++;
    if (reset) begin
      exp_phase = 0;
    end else if (!exp_wait[exp_phase]) begin
      exp_phase = next_phase(exp_phase);
    end else if (allow_accept && (phase !== 5'(exp_phase))) begin
      exp_phase    = next_phase(exp_phase);
      advances++;
      adv_latency  = since_rise;
      allow_accept = 1'b0;
    end
    checks++;
    assert (phase === 5'(exp_phase)) else begin
      failures++;
      $error("[TB] FAIL phase observed=%0d expected=%0d", phase, exp_phase);
    end
    checks++;
    assert (ctrl_obs === exp_ctrl[exp_phase]) else begin
      failures++;
      $error("[TB] FAIL ctrl phase=%0d observed=%b expected=%b", exp_phase, ctrl_obs, exp_ctrl[exp_phase]);
    end
    checks++;
    assert (waiting === exp_wait[exp_phase]) else begin
      failures++;
      $error("[TB] FAIL waiting phase=%0d observed=%b expected=%b", exp_phase, waiting, exp_wait[exp_phase]);
    end
  endtask

  // One key press of hi cycles followed by lo released cycles.
  task automatic apply_stimulus(input int hi, input int lo, input bit expect_accept);
    advances     = 0;
    adv_latency  = 0;
    since_rise   = 0;
    allow_accept = 1'b1;
    step         = 1'b1;
    repeat (hi) check_output();
    step = 1'b0;
    repeat (lo) check_output();
    allow_accept = 1'b0;
    checks++;
    assert (advances === (expect_accept ? 1 : 0)) else begin
      failures++;
      $error("[TB] FAIL advance_count hi=%0d observed=%0d expected=%0d", hi, advances, expect_accept ? 1 : 0);
    end
    if (expect_accept) begin
      checks++;
      assert (adv_latency >= DEB && adv_latency <= 8) else begin
        failures++;
        $error("[TB] FAIL accept_latency observed=%0d expected=%0d..8", adv_latency, DEB);
      end
    end
  endtask

  initial begin
    int hi;
    int lo;

    for (int i = 0; i < 27; i++) begin
      exp_ctrl[i] = 8'h00;
      exp_wait[i] = 1'b0;
    end
    foreach (exp_wait[i]) if (i inside {0, 2, 4, 6, 12, 15, 18, 20, 23, 26}) exp_wait[i] = 1'b1;
    exp_ctrl[1]  = LC;
    exp_ctrl[3]  = LC;
    exp_ctrl[5]  = LB;
    exp_ctrl[7]  = LB;
    exp_ctrl[8]  = LM | LB | SU;
    exp_ctrl[9]  = MU | SU;
    exp_ctrl[10] = LM | LB;
    exp_ctrl[11] = MU;
    exp_ctrl[13] = FB | LO;
    exp_ctrl[14] = LO;
    exp_ctrl[16] = LO | MS;
    exp_ctrl[17] = LO | SU;
    exp_ctrl[19] = MU;
    exp_ctrl[21] = FB | LO;
    exp_ctrl[22] = LO;
    exp_ctrl[24] = LO | MS;
    exp_ctrl[25] = LO | SU;

    exp_phase    = 0;
    allow_accept = 1'b0;
    advances     = 0;
    since_rise   = 0;
    adv_latency  = 0;
    reset        = 1'b1;
    step         = 1'b0;

    $display("[TB] reset");
    repeat (3) check_output();
    reset = 1'b0;
    repeat (10) check_output();

    $display("[TB] glitch, normal press, long hold, exact-window press");
    apply_stimulus(DEB - 1, 10, 1'b0);
    apply_stimulus(10, 10, 1'b1);
    apply_stimulus(200, 10, 1'b1);
    apply_stimulus(6, 12, 1'b1);
    apply_stimulus(DEB, 12, 1'b1);

    $display("[TB] random presses");
    for (int i = 0; i < 40; i++) begin
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1))
                                         : int'($urandom_range(DEB, 24));
      lo = int'($urandom_range(10, 16));
      apply_stimulus(hi, lo, hi >= DEB);
    end

    $display("[TB] reset during M2 with key held");
    for (int g = 0; g < 30 && exp_phase != 6; g++) apply_stimulus(6, 12, 1'b1);
    allow_accept = 1'b1;
    since_rise   = 0;
    step         = 1'b1;
    for (int g = 0; g < 20 && exp_phase != 9; g++) check_output();
    checks++;
    assert (phase === 5'd9) else begin
      failures++;
      $error("[TB] FAIL reach_m2 observed=%0d expected=9", phase);
    end
    allow_accept = 1'b0;
    reset        = 1'b1;
    repeat (3) check_output();
    reset = 1'b0;
    repeat (30) check_output();
    step = 1'b0;
    repeat (12) check_output();
    apply_stimulus(6, 12, 1'b1);
    checks++;
    assert (phase === 5'd2) else begin
      failures++;
      $error("[TB] FAIL after_reset_press observed=%0d expected=2", phase);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
